// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM demultiplexer: FSM state encoding and
// slot-counter sizing.
package tdm_pkg;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/deser_shift.sv
// MSB-first left-shift deserializer with enable; one instance per channel.
module deser_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= {q[WIDTH-2:0], din};
  end

endmodule

// File: rtl/tdm_demux_12.sv
// Two-channel TDM receiver: locks onto sync, deserializes even slots into A
// and odd slots into B, and strobes valid per frame or err on framing loss.
//
// state   | meaning
// ST_HUNT | waiting for sync; din ignored
// ST_RUN  | locked; cnt is the slot expected this cycle (0 = needs sync)
module tdm_demux_12
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             sync,
  output logic [WIDTH-1:0] ya,
  output logic [WIDTH-1:0] yb,
  output logic             valid,
  output logic             err
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            en_a, en_b, load, err_nxt;
  logic [WIDTH-1:0] a_q, b_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    en_a      = 1'b0;
    en_b      = 1'b0;
    load      = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_HUNT: begin
        if (sync) begin
          en_a      = 1'b1;
          cnt_nxt   = CW'(1);
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // A sync always restarts the frame; it is only an error off slot 0.
        if (sync) begin
          en_a    = 1'b1;
          cnt_nxt = CW'(1);
          err_nxt = (cnt != '0);
        end else if (cnt == '0) begin
          err_nxt   = 1'b1;
          state_nxt = ST_HUNT;
        end else begin
          en_a = ~cnt[0];
          en_b = cnt[0];
          if (cnt == LAST) begin
            load    = 1'b1;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_HUNT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A full frame needs no explicit clear: W shifts per channel flush old bits.
  deser_shift #(.WIDTH(WIDTH)) u_shift_a (
    .clk (clk),
    .rst (rst),
    .en  (en_a),
    .din (din),
    .q   (a_q)
  );

  deser_shift #(.WIDTH(WIDTH)) u_shift_b (
    .clk (clk),
    .rst (rst),
    .en  (en_b),
    .din (din),
    .q   (b_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ya    <= '0;
      yb    <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      // B's last bit arrives this cycle, so it is merged ahead of the shifter.
      if (load) begin
        ya <= a_q;
        yb <= {b_q[WIDTH-2:0], din};
      end
      valid <= load;
      err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_tdm_demux_12.sv
// Scoreboard bench for tdm_demux_12 (WIDTH=4): a slot-list reference model
// queues expected strobes; a negedge monitor checks them and the held words.
module tb_tdm_demux_12;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         din = 1'b0;
  logic         sync = 1'b0;
  logic [W-1:0] ya, yb;
  logic         valid, err;

  tdm_demux_12 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .sync  (sync),
    .ya    (ya),
    .yb    (yb),
    .valid (valid),
    .err   (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int           cyc;
    bit           is_err;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } ev_t;

  ev_t          exp_q[$];
  bit           bits_q[$];
  bit           in_frame = 1'b0;
  logic [W-1:0] held_a = '0, held_b = '0;
  int           checks = 0, passed = 0;

  task automatic check(input string name, input bit ok,
                       input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
  endtask

  // Reference: collect the slots of the current frame as a list and judge
  // framing from list length alone.
  task automatic model(input logic s, input logic d);
    ev_t e;
    e.cyc = cyc + 1;
    e.a = '0;
    e.b = '0;
    if (s) begin
      if (in_frame && bits_q.size() != 0) begin
        e.is_err = 1'b1;
        exp_q.push_back(e);
      end
      bits_q.delete();
      bits_q.push_back(d);
      in_frame = 1'b1;
    end else if (in_frame) begin
      if (bits_q.size() == 0) begin
        e.is_err = 1'b1;
        exp_q.push_back(e);
        in_frame = 1'b0;
      end else begin
        bits_q.push_back(d);
        if (bits_q.size() == 2 * W) begin
          for (int i = 0; i < W; i++) begin
            e.a[W-1-i] = bits_q[2*i];
            e.b[W-1-i] = bits_q[2*i+1];
          end
          e.is_err = 1'b0;
          exp_q.push_back(e);
          bits_q.delete();
        end
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    bits_q.delete();
    in_frame = 1'b0;
    held_a = '0;
    held_b = '0;
  endtask

  task automatic drive(input logic s, input logic d);
    @(posedge clk);
    #1;
    sync = s;
    din  = d;
    if (!rst) model(s, d);
  endtask

  task automatic partial(input logic [W-1:0] a, input logic [W-1:0] b, input int n);
    for (int k = 0; k < n; k++)
      drive(k == 0, (k % 2 == 0) ? a[W-1-k/2] : b[W-1-k/2]);
  endtask

  task automatic frame(input logic [W-1:0] a, input logic [W-1:0] b);
    partial(a, b, 2 * W);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'($urandom_range(0, 1)));
  endtask

  always @(negedge clk) begin
    bit  exp_strobe;
    ev_t e;
    if (rst) begin
      check("reset_outputs", {ya, yb, valid, err} == '0, 16'({ya, yb, valid, err}), 16'h0);
    end else begin
      check("no_valid_err_overlap", !(valid && err), 16'({valid, err}), 16'h0);
      exp_strobe = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      check("strobe_timing", (valid || err) == exp_strobe, 16'({valid, err}), 16'(exp_strobe));
      if (exp_strobe) begin
        e = exp_q.pop_front();
        check("strobe_kind", {valid, err} == {!e.is_err, e.is_err},
              16'({valid, err}), 16'({!e.is_err, e.is_err}));
        if (!e.is_err) begin
          held_a = e.a;
          held_b = e.b;
        end
      end
      check("ya_word", ya == held_a, 16'(ya), 16'(held_a));
      check("yb_word", yb == held_b, 16'(yb), 16'(held_b));
    end
  end

  initial begin
    // Reset held while inputs toggle.
    for (int i = 0; i < 8; i++) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    @(posedge clk);
    #1;
    rst  = 1'b0;
    sync = 1'b0;

    // Single frame 1,0,0,1,1,1,0,0 -> A=A, B=6, then sync goes missing.
    frame(4'hA, 4'h6);
    idle(3);

    // Back-to-back frames.
    frame(4'hF, 4'h0);
    frame(4'h3, 4'hC);
    idle(2);

    // Misplaced sync at slot 3, then a clean frame from the new slot 0.
    frame(4'h5, 4'h9);
    partial(4'h1, 4'h2, 3);
    frame(4'h7, 4'h2);

    // Missing sync, long gap, then recovery.
    idle(6);
    frame(4'hB, 4'hD);

    // Async reset between edges during slot 5.
    frame(4'hE, 4'h1);
    partial(4'h6, 4'h9, 6);
    #6;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_reset_ya", ya == '0, 16'(ya), 16'h0);
    check("async_reset_yb", yb == '0, 16'(yb), 16'h0);
    check("async_reset_strobes", {valid, err} == 2'b00, 16'({valid, err}), 16'h0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    sync = 1'b0;
    frame(4'hC, 4'h3);

    // Randomized mix of good frames, truncated frames and gaps.
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 70)      frame(4'($urandom), 4'($urandom));
      else if (r < 85) partial(4'($urandom), 4'($urandom), $urandom_range(1, 2 * W - 1));
      else             idle($urandom_range(1, 4));
    end

    idle(4);
    check("scoreboard_drained", exp_q.size() == 0, 16'(exp_q.size()), 16'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
